// File: rtl/redmule_eoc_pkg.sv
// Shared constants for the RedMulE virtual-peripheral responder: register offsets,
// response FSM states, STATUS bit positions and the byte-enable mask helper.
package redmule_eoc_pkg;

    localparam logic [3:0] EOC_OFF    = 4'h0;
    localparam logic [3:0] PUTC_OFF   = 4'h4;
    localparam logic [3:0] STATUS_OFF = 4'h8;
    localparam logic [3:0] TS_OFF     = 4'hC;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } eoc_state_e;

    localparam int STS_EMPTY = 0;
    localparam int STS_FULL  = 1;
    localparam int STS_EOC   = 2;
    localparam int STS_ERR   = 3;

    // Expand a 4-bit byte enable into a 32-bit data mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/redmule_eoc_char_fifo.sv
// Character FIFO: circular buffer with wrapping pointers and an occupancy count.
// The head byte is read straight from storage and qualified by valid_o.
module redmule_eoc_char_fifo
    import redmule_eoc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [7:0]       data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [7:0]       data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign valid_o = ~empty_o;
    assign count_o = count_q;
    // Gate the head so it reads zero while empty rather than stale storage.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : 8'h00;

    assign do_push = push_i & ~full_o;
    assign do_pop  = valid_o & ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/redmule_eoc_stdout.sv
// TCDM-style slave for the 0x8000_0000 virtual-peripheral window: EOC exit code,
// putchar FIFO, status. Optional cycle timestamp at 0xC under REDMULE_EOC_TIMESTAMP_EN.
module redmule_eoc_stdout
    import redmule_eoc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    output logic [31:0] r_data_o,
    output logic        r_valid_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic [7:0]  char_data_o,
    output logic        eoc_o,
    output logic [31:0] exit_code_o,
    output logic        addr_err_o
);

    // Bus handshake: a request is accepted in the cycle where req_i & gnt_o;
    // exactly one r_valid_o pulse follows in the next cycle, with r_data_o.

    eoc_state_e       state_q, state_d;
    logic [31:0]      r_data_q, r_data_d;
    logic [31:0]      exit_code_q, exit_code_d;
    logic             eoc_q, eoc_d;
    logic             addr_err_q, addr_err_d;

    logic             in_win;
    logic [1:0]       reg_sel;
    logic             sel_eoc, sel_putc, sel_status, sel_ts;
    logic             putc_wr;
    logic             fifo_push, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^add_i[1:0];

    assign in_win     = (add_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel    = add_i[3:2];
    assign sel_eoc    = in_win & (reg_sel == EOC_OFF[3:2]);
    assign sel_putc   = in_win & (reg_sel == PUTC_OFF[3:2]);
    assign sel_status = in_win & (reg_sel == STATUS_OFF[3:2]);
    assign sel_ts     = in_win & (reg_sel == TS_OFF[3:2]);

    // Only a byte-carrying putchar into a full FIFO is ever stalled; the pop
    // side deliberately has no path into gnt_o.
    assign putc_wr   = sel_putc & ~wen_i & be_i[0];
    assign gnt_o     = req_i & ~(putc_wr & fifo_full);
    assign fifo_push = gnt_o & putc_wr;

`ifdef REDMULE_EOC_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;

    always_comb begin
        ts_d = eoc_q ? ts_q : ts_q + 32'd1;
        if (gnt_o && sel_ts && !wen_i) ts_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_o)  state_d = RESP;
            RESP:    if (!gnt_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_data_d = '0;
        if (gnt_o && wen_i) begin
            if (sel_eoc) begin
                r_data_d = exit_code_q;
            end else if (sel_putc) begin
                r_data_d = 32'(fifo_count);
            end else if (sel_status) begin
                r_data_d[STS_EMPTY] = fifo_empty;
                r_data_d[STS_FULL]  = fifo_full;
                r_data_d[STS_EOC]   = eoc_q;
                r_data_d[STS_ERR]   = addr_err_q;
            end else if (sel_ts) begin
`ifdef REDMULE_EOC_TIMESTAMP_EN
                r_data_d = ts_q;
`else
                r_data_d = '0;
`endif
            end
        end
    end

    always_comb begin
        exit_code_d = exit_code_q;
        eoc_d       = eoc_q;
        addr_err_d  = addr_err_q | (gnt_o & ~in_win);
        // First EOC write wins; later ones are accepted but dropped.
        if (gnt_o && sel_eoc && !wen_i && !eoc_q) begin
            exit_code_d = data_i & be_to_mask(be_i);
            eoc_d       = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            r_data_q    <= '0;
            exit_code_q <= '0;
            eoc_q       <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_data_q    <= r_data_d;
            exit_code_q <= exit_code_d;
            eoc_q       <= eoc_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign r_valid_o   = (state_q == RESP);
    assign r_data_o    = r_data_q;
    assign eoc_o       = eoc_q;
    assign exit_code_o = exit_code_q;
    assign addr_err_o  = addr_err_q;

    redmule_eoc_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_char_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (data_i[7:0]),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .valid_o (char_valid_o),
        .ready_i (char_ready_i),
        .data_o  (char_data_o),
        .count_o (fifo_count)
    );

endmodule

// File: doc/redmule_eoc_stdout.md
Name: redmule_eoc_stdout

Overview:
- Synthesizable TCDM-style responder for the core's "virtual peripheral" window at 0x8000_0000.
- Accepts end-of-computation (exit code) and putchar writes from the core data port.
- Buffers characters in a FIFO drained over a valid/ready stream.
- Raises an EOC flag with the latched exit code, replacing bench-side address snooping with a real slave that honours gnt/r_valid.

Parameters:
- BASE_ADDR, 32'h8000_0000, window base; decode on add[31:4] == BASE_ADDR[31:4].
- FIFO_DEPTH, 16, character FIFO entries; power of two, >= 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  request
- gnt_o  out  1  grant (combinational)
- add_i  in  32  byte address
- wen_i  in  1  1 = read, 0 = write (TCDM convention)
- be_i  in  4  byte enables
- data_i  in  32  write data
- r_data_o  out  32  read data, valid with r_valid_o
- r_valid_o  out  1  response strobe, one per granted request
- char_valid_o  out  1  FIFO head valid
- char_ready_i  in  1  consumer ready
- char_data_o  out  8  FIFO head byte
- eoc_o  out  1  exit code written (sticky)
- exit_code_o  out  32  latched exit code
- addr_err_o  out  1  sticky: granted access outside the window or to an unmapped offset

Behaviour:
- Reset (rst_i high at posedge) clears everything: r_valid_o=0, r_data_o=0, char_valid_o=0, char_data_o=0, eoc_o=0, exit_code_o=0, addr_err_o=0, FIFO empty. Reset mid-operation drops any pending response and discards FIFO contents.
- Register map, by add[3:2]:
  - 0x0 EOC. Write: if eoc_o=0, exit_code <= data_i masked by be_i (unenabled bytes 0) and eoc_o <= 1. If eoc_o=1, the write is ignored (first write wins). Read: exit_code.
  - 0x4 PUTC. Write with be_i[0]=1 pushes data_i[7:0]; with be_i[0]=0 it is granted, no push. Read: {24'b0, occupancy}.
  - 0x8 STATUS. Read: {28'b0, addr_err, eoc, full, empty}. Writes ignored.
  - 0xC TIMESTAMP, see Optional Feature.
- Grant: gnt_o = req_i & ~(PUTC write & be_i[0] & full). This is the only backpressure. gnt_o has no combinational path from char_ready_i: a pop in the same cycle does not free a slot for a push.
- Response: every granted request (read or write) gets r_valid_o=1 exactly one cycle later. r_data_o is registered; it is 0 for writes and for unmapped reads. Back-to-back grants give back-to-back r_valid.
- Out-of-window address (add[31:4] mismatch): granted, no side effects, r_data 0, addr_err_o <= 1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers plus occupancy count.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - Head is shown on char_valid_o/char_data_o (fall-through registered storage). A pop happens when char_valid_o & char_ready_i.
  - Push and pop in the same cycle leave count unchanged; when empty, the pushed byte is visible the next cycle.
  - char_data_o is stable while char_valid_o & ~char_ready_i.
- The FSM for the response channel has two states: IDLE and RESP. RESP is held while grants continue.

Optional Feature:
- Macro REDMULE_EOC_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter, zero at reset, wraps at 2^32.
  - Read 0xC returns the counter value sampled at grant.
  - Write 0xC clears it, and the write wins over the increment in that cycle.
  - On the first EOC write, the counter freezes (the performance stop time).
- Undefined: 0xC reads 0, writes have no effect, no counter flops.

Decomposition:
- Package redmule_eoc_pkg holds:
  - the offset constants EOC_OFF=4'h0, PUTC_OFF=4'h4, STATUS_OFF=4'h8, TS_OFF=4'hC;
  - the enum eoc_state_e {IDLE, RESP};
  - the STATUS bit positions.
- Sub-module redmule_eoc_char_fifo (parametric depth, push/full, valid/ready pop side, count output).

Test Plan:
- Reset, then write 0x4 with 'H' (0x48), 'i' (0x69), char_ready_i=1 -> gnt same cycle, r_valid +1; char stream emits 0x48 then 0x69; STATUS reads 0x1.
- char_ready_i=0, 17 PUTC writes with FIFO_DEPTH=16 -> 16 granted; the 17th stalls with gnt=0 and STATUS=0x2. Raise ready for 1 cycle -> the 17th is granted the following cycle, and the output order is preserved across pointer wrap.
- Write EOC 0x0000_0000 with be=4'hF, then EOC 0xDEAD_BEEF -> eoc_o=1 one cycle after the first grant; exit_code_o stays 0; a read of 0x0 returns 0.
- Read 0x8000_0010 and write 0x9000_0000 -> both granted, r_data 0, addr_err_o=1 sticky; STATUS bit3=1.
- Assert rst_i with 5 chars queued and a response pending -> next cycle FIFO empty, r_valid_o=0, eoc_o=0.
- (TIMESTAMP_EN) Write 0xC, wait 100 cycles, read -> value 100±1 per the defined sampling point; after an EOC write, two reads 50 cycles apart return the same value.
